// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48 multiply-accumulate sequencer.
package dsp_seq_pkg;

  localparam int OPND_W = 18;
  localparam int PROD_W = 36;
  localparam int ACC_W  = 48;
  localparam int CNT_W  = 16;
  localparam int OPM_W  = 8;

  // Z=0, X=M for the first beat; Z=P, X=M to accumulate every later beat.
  localparam logic [OPM_W-1:0] OP_MULT = 8'h01;
  localparam logic [OPM_W-1:0] OP_MAC  = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/dsp_seq_delay.sv
// Fixed-depth shift register with synchronous clear; output is always a flop.
// Latency is DEPTH cycles, no backpressure.
module dsp_seq_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams operand pairs into an external DSP slice and returns the accumulated sum per job.
// Result appears SLICE_LAT+1 cycles after the last beat; s_ready stays low until the result retires.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int SLICE_LAT = 3,
  parameter int OPM_LEAD  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [OPND_W-1:0] s_a,
  input  logic [OPND_W-1:0] s_b,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic [CNT_W-1:0]  m_count,
  output logic [OPND_W-1:0] dsp_a,
  output logic [OPND_W-1:0] dsp_b,
  output logic [OPM_W-1:0]  dsp_opmode,
  output logic              dsp_ce,
  output logic              dsp_rst,
  input  logic [ACC_W-1:0]  dsp_p
);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept;
  logic             last_accept;
  logic             drain_done;
  logic [OPM_W-1:0] op_next;

  assign accept      = s_valid && s_ready;
  assign last_accept = accept && s_last;

  // Only a beat taken from IDLE starts a fresh sum; bubbles and drain cycles add a zero product.
  assign op_next = (state == ST_IDLE) ? OP_MULT : OP_MAC;

  // One extra stage because the opmode is registered at the acceptance edge like the operands.
  dsp_seq_delay #(
    .WIDTH (OPM_W),
    .DEPTH (OPM_LEAD + 1)
  ) u_opm_delay (
    .clk  (CLK),
    .rst  (RST),
    .din  (op_next),
    .dout (dsp_opmode)
  );

  // Rises in the cycle before P of the last beat is safe to sample.
  dsp_seq_delay #(
    .WIDTH (1),
    .DEPTH (SLICE_LAT + 1)
  ) u_done_delay (
    .clk  (CLK),
    .rst  (RST),
    .din  (last_accept),
    .dout (drain_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_count  <= '0;
      beat_cnt <= '0;
      dsp_a    <= '0;
      dsp_b    <= '0;
      dsp_ce   <= 1'b0;
      dsp_rst  <= 1'b1;
    end else begin
      dsp_rst <= 1'b0;
      dsp_a   <= accept ? s_a : '0;
      dsp_b   <= accept ? s_b : '0;
      case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            beat_cnt <= CNT_W'(1);
            dsp_ce   <= 1'b1;
            if (s_last) begin
              state   <= ST_DRAIN;
              s_ready <= 1'b0;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (s_last) begin
              state   <= ST_DRAIN;
              s_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state   <= ST_HOLD;
            dsp_ce  <= 1'b0;
            m_valid <= 1'b1;
            m_data  <= dsp_p;
            m_count <= beat_cnt;
          end
        end
        ST_HOLD: begin
          if (m_valid && m_ready) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          dsp_ce  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP slice plus directed job table and corner sequences.
module tb_dsp_mac_sequencer;
  import dsp_seq_pkg::*;

  localparam int SLICE_LAT = 3;
  localparam int OPM_LEAD  = 1;
  localparam int LAT       = SLICE_LAT + 1;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [17:0] s_a     = '0;
  logic [17:0] s_b     = '0;
  logic        s_last  = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [47:0] m_data;
  logic [15:0] m_count;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst;
  logic [47:0] dsp_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .SLICE_LAT (SLICE_LAT),
    .OPM_LEAD  (OPM_LEAD)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_count    (m_count),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rst    (dsp_rst),
    .dsp_p      (dsp_p)
  );

  // Slice model: A1/B1, M, OPMODE and P registers, all gated by one CE.
  logic [17:0]       a1, b1;
  logic [PROD_W-1:0] m_reg;
  logic [7:0]        opm_reg;
  logic [47:0]       p_reg;

  always_ff @(posedge clk) begin
    if (dsp_rst) begin
      a1      <= '0;
      b1      <= '0;
      m_reg   <= '0;
      opm_reg <= '0;
      p_reg   <= '0;
    end else if (dsp_ce) begin
      a1      <= dsp_a;
      b1      <= dsp_b;
      m_reg   <= 36'(a1) * 36'(b1);
      opm_reg <= dsp_opmode;
      p_reg   <= (opm_reg[3] ? p_reg : 48'd0) +
                 ((opm_reg[1:0] == 2'b01) ? {12'd0, m_reg} : 48'd0);
    end
  end

  assign dsp_p = p_reg;

  typedef struct {
    int               nbeats;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    int               gap_after;
    int               gap_len;
    logic             rdy_early;
    logic [47:0]      exp_data;
    logic [15:0]      exp_count;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mkv(input int n,
                               input logic [17:0] a0, b0, a1_, b1_, a2, b2, a3, b3,
                               input int ga, gl, input logic re,
                               input logic [47:0] d, input logic [15:0] c);
    vec_t v;
    v.nbeats    = n;
    v.a         = {a3, a2, a1_, a0};
    v.b         = {b3, b2, b1_, b0};
    v.gap_after = ga;
    v.gap_len   = gl;
    v.rdy_early = re;
    v.exp_data  = d;
    v.exp_count = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
    int guard = 0;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("beat_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    s_last  = 1'b0;
    check("beat_ab", 64'({dsp_a, dsp_b}), 64'({a, b}));
  endtask

  task automatic wait_valid(input int start, output int n);
    n = start;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic retire();
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    check("retired", 64'({m_valid, s_ready, dsp_ce}), 64'(3'b010));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, 64'({s_ready, m_valid, dsp_ce, dsp_rst}), 64'(4'b0001));
    check({tag, "_dsp"}, 64'({dsp_a, dsp_b, dsp_opmode}), 64'(0));
    check({tag, "_m"}, {m_data, m_count}, 64'(0));
  endtask

  task automatic run_vec(input int k);
    int n;
    m_ready = vecs[k].rdy_early;
    for (int i = 0; i < vecs[k].nbeats; i++) begin
      drive_beat(vecs[k].a[i], vecs[k].b[i], (i == vecs[k].nbeats - 1));
      if (i == vecs[k].gap_after) begin
        for (int g = 0; g < vecs[k].gap_len; g++) begin
          @(negedge clk);
          check($sformatf("v%0d_bubble_ab", k), 64'({dsp_a, dsp_b}), 64'(0));
        end
      end
    end
    check($sformatf("v%0d_drain", k), 64'({s_ready, dsp_ce}), 64'(2'b01));
    wait_valid(0, n);
    check($sformatf("v%0d_latency", k), 64'(n), 64'(LAT));
    check($sformatf("v%0d_data", k), 64'(m_data), 64'(vecs[k].exp_data));
    check($sformatf("v%0d_count", k), 64'(m_count), 64'(vecs[k].exp_count));
    retire();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic seen;

    vecs[0] = mkv(1, 3, 4, 0, 0, 0, 0, 0, 0, -1, 0, 1'b0, 48'd12, 16'd1);
    vecs[1] = mkv(4, 1, 2, 3, 4, 5, 6, 7, 8, -1, 0, 1'b1, 48'd100, 16'd4);
    vecs[2] = mkv(4, 1, 2, 3, 4, 5, 6, 7, 8, 1, 2, 1'b0, 48'd100, 16'd4);
    vecs[3] = mkv(2, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 0, 0, 0, 0,
                  -1, 0, 1'b0, 48'h1F_FFF0_0002, 16'd2);
    vecs[4] = mkv(3, 100, 200, 1, 1, 18'h3FFFF, 1, 0, 0, 0, 3, 1'b0, 48'd282144, 16'd3);
    vecs[5] = mkv(2, 0, 5, 6, 0, 0, 0, 0, 0, -1, 0, 1'b0, 48'd0, 16'd2);

    repeat (3) @(negedge clk);
    check_reset("init");
    rst = 1'b0;
    @(negedge clk);
    check("release", 64'({dsp_rst, s_ready, dsp_ce}), 64'(3'b010));

    for (int k = 0; k < 6; k++) run_vec(k);

    // First beat carries OP_MULT, second OP_MAC, each one cycle after its operands.
    drive_beat(3, 4, 1'b0);
    drive_beat(1, 1, 1'b1);
    check("opm_first", 64'(dsp_opmode), 64'(OP_MULT));
    @(negedge clk);
    check("opm_mac", 64'(dsp_opmode), 64'(OP_MAC));
    wait_valid(1, n);
    check("opm_latency", 64'(n), 64'(LAT));
    check("opm_data", 64'(m_data), 64'(48'd13));
    check("opm_count", 64'(m_count), 64'(16'd2));
    retire();

    // Result held under backpressure while a new beat is offered.
    drive_beat(2, 3, 1'b1);
    wait_valid(0, n);
    check("bp_latency", 64'(n), 64'(LAT));
    s_valid = 1'b1;
    s_a     = 18'd9;
    s_b     = 18'd9;
    s_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_data", 64'(m_data), 64'(48'd6));
      check("bp_flags", 64'({m_valid, s_ready, m_count}), 64'({1'b1, 1'b0, 16'd1}));
    end
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    s_last  = 1'b0;
    retire();

    // Reset mid-job discards the partial sum.
    drive_beat(1, 2, 1'b0);
    drive_beat(3, 4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release", 64'({dsp_rst, s_ready}), 64'(2'b01));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'(0));
    drive_beat(2, 5, 1'b1);
    wait_valid(0, n);
    check("post_rst_latency", 64'(n), 64'(LAT));
    check("post_rst_data", 64'(m_data), 64'(48'd10));
    check("post_rst_count", 64'(m_count), 64'(16'd1));
    retire();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter SLICE_LAT, default 3, gives the operand-to-P latency in cycles of the attached DSP slice (A1/B1, M and P registered).
REQ-002 Parameter OPM_LEAD, default 1, gives the cycles by which the slice OPMODE for a beat trails that beat's operands.
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 s_valid / s_ready  in / out  1 / 1  operand stream handshake.
REQ-006 s_a, s_b  in  18 each  unsigned operand pair.
REQ-007 s_last  in  1  marks the final beat of a job.
REQ-008 m_valid / m_ready  out / in  1 / 1  result handshake.
REQ-009 m_data  out  48  accumulated sum of products.
REQ-010 m_count  out  16  number of beats in the job, wrapping modulo 2^16.
REQ-011 dsp_a, dsp_b  out  18 each  drive slice A and B (B_INPUT direct).
REQ-012 dsp_opmode  out  8  drives slice OPMODE.
REQ-013 dsp_ce  out  1  drives slice CEA/CEB/CEM/CEP/CEOPMODE.
REQ-014 dsp_rst  out  1  drives all slice RSTx inputs.
REQ-015 dsp_p  in  48  slice P output.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and HOLD.
REQ-017 IDLE -> ISSUE on the first accepted beat; ISSUE -> DRAIN on acceptance of the s_last beat; DRAIN -> HOLD after SLICE_LAT+1 cycles; HOLD -> IDLE on m_valid && m_ready.
REQ-018 s_ready SHALL be 1 in IDLE and ISSUE and 0 in DRAIN and HOLD, so that jobs never overlap.
REQ-019 dsp_a, dsp_b and dsp_opmode SHALL be registered outputs.
REQ-020 On a beat accepted at edge E, dsp_a/dsp_b SHALL take s_a/s_b at E and that beat's OPMODE SHALL appear on dsp_opmode at E+OPM_LEAD.
REQ-021 OPMODE for the first beat of a job SHALL be OP_MULT (8'h01: Z=0, X=M, no pre-adder, no carry, add).
REQ-022 OPMODE for every later beat SHALL be OP_MAC (8'h09: Z=P, X=M).
REQ-023 In an ISSUE cycle with s_valid=0 (bubble), dsp_a and dsp_b SHALL be driven to 0 with OP_MAC, so that a zero product accumulates; bubbles SHALL NOT increment m_count.
REQ-024 dsp_ce SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and HOLD.
REQ-025 m_data SHALL capture dsp_p exactly SLICE_LAT+1 edges after the s_last acceptance edge, and m_valid SHALL rise at that same edge.
REQ-026 m_data and m_count SHALL remain stable while m_valid=1 and m_ready=0.
REQ-027 Arithmetic SHALL be unsigned: 36-bit products are zero-extended, the 48-bit sum wraps modulo 2^48, and slice carry-out is ignored.
REQ-028 A job whose first beat has s_last=1 SHALL produce the single product.
REQ-029 m_valid and m_ready SHALL be allowed to be high in the same cycle as DRAIN completion; the result is registered first and retired on a later edge.

Reset
REQ-030 While RST=1: state=IDLE, m_valid=0, s_ready=0, m_data=0, m_count=0, dsp_a=0, dsp_b=0, dsp_opmode=0, dsp_ce=0, dsp_rst=1.
REQ-031 dsp_rst SHALL deassert on the first edge with RST=0, and s_ready SHALL be 1 from that edge on.
REQ-032 RST asserted mid-job SHALL discard the job with no m_valid pulse, and the next job SHALL start from OP_MULT.

Structure
REQ-033 Package dsp_seq_pkg SHALL hold the state enum, OP_MULT, OP_MAC and the width constants (18, 36, 48).
REQ-034 One sub-module, dsp_seq_delay (parameterised shift register), SHALL align OPMODE and the done flag.

Verification
REQ-035 Single beat (3,4,last) -> m_data=12 and m_count=1; m_valid rises 4 edges after acceptance.
REQ-036 Beats (1,2),(3,4),(5,6),(7,8,last) back-to-back -> m_data=100, m_count=4.
REQ-037 Same job with 2 bubbles inserted after beat 2 -> m_data=100, m_count=4; dsp_a=dsp_b=0 during the bubbles.
REQ-038 (3FFFF,3FFFF) x2 -> m_data=48'h1_FFFF_0000_2 (2x0xF_FFF8_0001 = 0x1F_FFF0_0002), with no truncation.
REQ-039 m_ready held 0 for 10 cycles after m_valid -> m_data stable, s_ready=0, no new job accepted.
REQ-040 RST pulse after beat 2 of 4 -> no m_valid; the next job (2,5,last) returns 10.
